button_conditioner: RTL

- Conditions the raw active-low board push-button. The raw input is synchronised, debounced and classified.
- Produces a clean level plus single-cycle press, release and long-press pulses.
- Sits directly upstream of the LED flasher and other LED/pattern blocks; they consume the pulses instead of sampling the raw pin.
- Operates in the single system clock domain.

---
 rtl/btn_pkg.sv | 19 +
 rtl/button_conditioner_if.sv | 31 +++
 rtl/sync_chain.sv | 27 ++
 rtl/button_conditioner.sv | 137 +++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Cycle counts are derived from the board clock so retargeting only touches CLK_HZ.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } btn_state_t;

  localparam int CLK_HZ        = 27_000_000;
  localparam int DEBOUNCE_MS   = 10;
  localparam int LONG_PRESS_MS = 1000;

  localparam int DEBOUNCE_CYCLES_DEF   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int LONG_PRESS_CYCLES_DEF = (CLK_HZ / 1000) * LONG_PRESS_MS;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button input plus the conditioned level and event pulses.
// master = the conditioner, slave = the button source / event consumer.
interface button_conditioner_if;
  import btn_pkg::*;

  logic btn_n;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;
  logic long_held;

  modport master (
    input  btn_n,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_press_pulse,
    output long_held
  );

  modport slave (
    output btn_n,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press_pulse,
    input  long_held
  );

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit board input.
// Latency STAGES clocks; flops preset to RST_VAL so an idle input reads inactive out of reset.
module sync_chain
  import btn_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and classifies an active-low push-button into level and event pulses.
// Press/release pulses land SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after a stable input change.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.master btn
);

  localparam int            CW        = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_PRESS_CYCLES - 1);

  logic sync_q;
  logic s;

  sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn.btn_n),
    .q     (sync_q)
  );

  assign s = ~sync_q;

  btn_state_t    state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] hold_next;
  logic          long_fired_q, long_fired_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          held_q, held_d;

  // Saturating so a long press missed during a release glitch still fires on return.
  assign hold_next = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    held_d       = held_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = PRESSED;
          press_d      = 1'b1;
          level_d      = 1'b1;
          hold_cnt_d   = '0;
          long_fired_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        hold_cnt_d = hold_next;
        if (!s) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST && !long_fired_q) begin
          long_d       = 1'b1;
          held_d       = 1'b1;
          long_fired_d = 1'b1;
        end
      end
      DB_RELEASE: begin
        hold_cnt_d = hold_next;
        if (s) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          held_d    = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      held_q       <= held_d;
    end
  end

  assign btn.btn_level        = level_q;
  assign btn.press_pulse      = press_q;
  assign btn.release_pulse    = release_q;
  assign btn.long_press_pulse = long_q;
  assign btn.long_held        = held_q;

endmodule
